// File: rtl/register_dump_pkg.sv
// register_dump_pkg: shared states, defaults and frame sizing for register_dump_streamer
package register_dump_pkg;
  typedef enum logic [2:0] {IDLE, HEADER, COUNT, PAYLOAD, CHECKSUM} state_t;
  localparam logic [7:0] DEFAULT_HEADER_BYTE = 8'h44;
  localparam int BYTES_PER_WORD = 4;
  function automatic int frame_length(input int xlen, input int num_regs, input bit checksum);
    return 2 + (num_regs + 1) * (xlen / 8) + (checksum ? 1 : 0);
  endfunction
endpackage

// File: rtl/register_dump_streamer.sv
// register_dump_streamer: snapshots pc + register file on trigger and streams it as a framed byte packet
//   clock/clear      : clock, synchronous active-high reset
//   trigger          : dump request, accepted only while idle
//   pc, registers    : live state; register i at [i*XLEN +: XLEN]
//   out_data/valid/ready : byte stream, transfer when valid && ready
//   busy, done, trigger_dropped : frame in progress, end-of-frame pulse, ignored-trigger pulse
//   REGISTER_DUMP_CHECKSUM_EN : appends a mod-256 sum of count and payload bytes
module register_dump_streamer
  import register_dump_pkg::*;
#(
  parameter int XLEN = 8 * BYTES_PER_WORD,
  parameter int NUM_REGS = 32,
  parameter logic [7:0] HEADER_BYTE = DEFAULT_HEADER_BYTE
) (
  input  logic                     clock,
  input  logic                     clear,
  input  logic                     trigger,
  input  logic [XLEN-1:0]          pc,
  input  logic [NUM_REGS*XLEN-1:0] registers,
  output logic [7:0]               out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     busy,
  output logic                     done,
  output logic                     trigger_dropped
);
  localparam int BPW = XLEN / 8;
  localparam int WW = $clog2(NUM_REGS + 1);
  localparam int BW = BPW > 1 ? $clog2(BPW) : 1;
  localparam int SW = (NUM_REGS + 1) * XLEN;
  localparam logic [7:0] COUNT_BYTE = 8'(NUM_REGS + 1);
  state_t state_q, state_d;
  logic [WW-1:0] widx_q, widx_d;
  logic [BW-1:0] bidx_q, bidx_d;
  logic [SW-1:0] snap_q, snap_d;
  logic done_q, done_d, drop_q, drop_d;
  logic [XLEN-1:0] word;
  logic [7:0] pay_byte, tail_byte;
  logic xfer, last_byte, last_word;
`ifdef REGISTER_DUMP_CHECKSUM_EN
  logic [7:0] sum_q, sum_d;
  assign tail_byte = state_q == CHECKSUM ? sum_q : 8'h00;
`else
  assign tail_byte = 8'h00;
`endif
  // word 0 of the snapshot is pc, words 1..NUM_REGS are the registers
  assign word = snap_q[widx_q * XLEN +: XLEN];
  assign pay_byte = word[bidx_q * 8 +: 8];
  assign out_valid = state_q != IDLE;
  assign busy = out_valid;
  assign done = done_q;
  assign trigger_dropped = drop_q;
  assign xfer = out_valid && out_ready;
  assign last_byte = bidx_q == BW'(BPW - 1);
  assign last_word = widx_q == WW'(NUM_REGS);
  assign out_data = state_q == HEADER ? HEADER_BYTE :
                    state_q == COUNT ? COUNT_BYTE :
                    state_q == PAYLOAD ? pay_byte : tail_byte;
  always_comb begin
    state_d = state_q;
    widx_d = widx_q;
    bidx_d = bidx_q;
    snap_d = snap_q;
    done_d = 1'b0;
    drop_d = trigger && state_q != IDLE;
`ifdef REGISTER_DUMP_CHECKSUM_EN
    sum_d = sum_q;
`endif
    case (state_q)
      IDLE: if (trigger) begin
        state_d = HEADER;
        snap_d = {registers, pc};
        widx_d = '0;
        bidx_d = '0;
`ifdef REGISTER_DUMP_CHECKSUM_EN
        sum_d = 8'h00;
`endif
      end
      HEADER: state_d = xfer ? COUNT : HEADER;
      COUNT: if (xfer) begin
        state_d = PAYLOAD;
`ifdef REGISTER_DUMP_CHECKSUM_EN
        sum_d = sum_q + COUNT_BYTE;
`endif
      end
      PAYLOAD: if (xfer) begin
`ifdef REGISTER_DUMP_CHECKSUM_EN
        sum_d = sum_q + pay_byte;
`endif
        bidx_d = last_byte ? '0 : bidx_q + 1'b1;
        widx_d = last_byte && !last_word ? widx_q + 1'b1 : widx_q;
        if (last_byte && last_word) begin
`ifdef REGISTER_DUMP_CHECKSUM_EN
          state_d = CHECKSUM;
`else
          state_d = IDLE;
          done_d = 1'b1;
`endif
        end
      end
      default: if (xfer) begin
        state_d = IDLE;
        done_d = 1'b1;
      end
    endcase
  end
  always_ff @(posedge clock) begin
    if (clear) begin
      state_q <= IDLE;
      widx_q <= '0;
      bidx_q <= '0;
      snap_q <= '0;
      done_q <= 1'b0;
      drop_q <= 1'b0;
    end else begin
      state_q <= state_d;
      widx_q <= widx_d;
      bidx_q <= bidx_d;
      snap_q <= snap_d;
      done_q <= done_d;
      drop_q <= drop_d;
    end
  end
`ifdef REGISTER_DUMP_CHECKSUM_EN
  always_ff @(posedge clock) begin
    if (clear) sum_q <= 8'h00;
    else sum_q <= sum_d;
  end
`endif
endmodule
